// File: rtl/spi_bitrev_pkg.sv
// Shared types, constants and the bit-reverse helper for the SPI bit-reverse slave.
package spi_bitrev_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_TXRX = 2'd2
  } state_t;

  localparam int unsigned FRAME_CNT_W  = 16;
  localparam int unsigned BITREV_MAX_W = 64;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bit_reverse(
    input logic [BITREV_MAX_W-1:0] v,
    input int unsigned             w
  );
    logic [BITREV_MAX_W-1:0] r;
    logic [5:0]              idx;
    r   = '0;
    idx = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < int'(w)) begin
        idx  = 6'(int'(w) - 1 - i);
        r[i] = v[idx];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_bitrev_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses on the synced level.
module spi_bitrev_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic dout,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign dout   = chain_q[STAGES-1];
  assign rise_c = chain_q[STAGES-1] & ~prev_q;
  assign fall_c = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI mode-0 slave that echoes each received word bit-reversed during the next word slot.
// Optional completed-frame counter output enabled by defining SPI_BITREV_FRAME_CNT_EN.
module spi_bitrev_slave
  import spi_bitrev_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MSB_FIRST   = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_word,
  output logic             frame_done,
  output logic             busy
`ifdef SPI_BITREV_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic sck_level_unused;
  logic sck_rise;
  logic sck_fall;
  logic ss_s;
  logic ss_rise_unused;
  logic ss_fall_unused;
  logic mosi_s;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  spi_bitrev_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock  (clock),
    .resetn (resetn),
    .din    (sck),
    .dout   (sck_level_unused),
    .rise_c (sck_rise),
    .fall_c (sck_fall)
  );

  spi_bitrev_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clock  (clock),
    .resetn (resetn),
    .din    (ss),
    .dout   (ss_s),
    .rise_c (ss_rise_unused),
    .fall_c (ss_fall_unused)
  );

  spi_bitrev_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock  (clock),
    .resetn (resetn),
    .din    (mosi),
    .dout   (mosi_s),
    .rise_c (mosi_rise_unused),
    .fall_c (mosi_fall_unused)
  );

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-2:0] rx_shift_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] pending_q;
  logic             load_pend_q;

  logic             clear_c;
  logic             sample_c;
  logic             complete_c;
  logic             tx_step_c;
  logic [WIDTH-1:0] rx_next_c;
  logic [WIDTH-1:0] rev_c;

  // rx_next_c holds the word with the first-arriving bit at index 0.
  assign rx_next_c = {mosi_s, rx_shift_q};
  assign rev_c     = WIDTH'(bit_reverse(BITREV_MAX_W'(rx_next_c), WIDTH));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; a synced ss release always wins.
  always_comb begin
    state_d    = state_q;
    clear_c    = 1'b0;
    sample_c   = 1'b0;
    complete_c = 1'b0;
    tx_step_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!ss_s) begin
          state_d = S_RX;
          clear_c = 1'b1;
        end
      end
      S_RX, S_TXRX: begin
        if (ss_s) begin
          state_d = S_IDLE;
          clear_c = 1'b1;
        end else begin
          if (sck_rise) begin
            sample_c = 1'b1;
            if (cnt_q == CNT_LAST) begin
              complete_c = 1'b1;
              state_d    = S_TXRX;
            end
          end
          if ((state_q == S_TXRX) && sck_fall) begin
            tx_step_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        clear_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      pending_q   <= '0;
      load_pend_q <= 1'b0;
      rx_word     <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done <= complete_c;
      busy       <= ~ss_s;
      if (clear_c) begin
        cnt_q       <= '0;
        rx_shift_q  <= '0;
        tx_shift_q  <= '0;
        pending_q   <= '0;
        load_pend_q <= 1'b0;
      end else begin
        if (sample_c) begin
          rx_shift_q <= rx_next_c[WIDTH-1:1];
          cnt_q      <= complete_c ? '0 : cnt_q + CNT_W'(1);
        end
        if (complete_c) begin
          pending_q   <= rev_c;
          load_pend_q <= 1'b1;
          rx_word     <= (MSB_FIRST != 0) ? rev_c : rx_next_c;
        end
        // First falling edge after a completed word loads it; later ones shift it out.
        if (tx_step_c) begin
          if (load_pend_q) begin
            tx_shift_q  <= pending_q;
            load_pend_q <= 1'b0;
          end else begin
            tx_shift_q <= {1'b0, tx_shift_q[WIDTH-1:1]};
          end
        end
      end
    end
  end

  assign miso = ss ? 1'b1 : tx_shift_q[0];

`ifdef SPI_BITREV_FRAME_CNT_EN
  // Saturating count of completed words; survives chip-select cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
    end else if (frame_done && (frame_cnt != {FRAME_CNT_W{1'b1}})) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Randomised bench for spi_bitrev_slave: an 8-bit LSB-assembly instance and a 13-bit MSB-assembly instance.
module tb_spi_bitrev_slave;

  localparam int W0 = 8;
  localparam int W1 = 13;

  logic          clock;
  logic          resetn;
  logic          sck;
  logic          ss0;
  logic          ss1;
  logic          mosi;
  logic          miso0;
  logic          miso1;
  logic [W0-1:0] rxw0;
  logic [W1-1:0] rxw1;
  logic          fd0;
  logic          fd1;
  logic          busy0;
  logic          busy1;
`ifdef SPI_BITREV_FRAME_CNT_EN
  logic [15:0]   fc0;
  logic [15:0]   fc1;
`endif

  int checks;
  int errors;
  int done0;
  int done1;

  logic [63:0] words_q[$];
  logic [63:0] got_q[$];
  logic [63:0] rx_q[$];
  logic        busy_mid;

  spi_bitrev_slave #(.WIDTH(W0), .SYNC_STAGES(2), .MSB_FIRST(0)) u_dut0 (
    .clock      (clock),
    .resetn     (resetn),
    .sck        (sck),
    .ss         (ss0),
    .mosi       (mosi),
    .miso       (miso0),
    .rx_word    (rxw0),
    .frame_done (fd0),
    .busy       (busy0)
`ifdef SPI_BITREV_FRAME_CNT_EN
    ,
    .frame_cnt  (fc0)
`endif
  );

  spi_bitrev_slave #(.WIDTH(W1), .SYNC_STAGES(2), .MSB_FIRST(1)) u_dut1 (
    .clock      (clock),
    .resetn     (resetn),
    .sck        (sck),
    .ss         (ss1),
    .mosi       (mosi),
    .miso       (miso1),
    .rx_word    (rxw1),
    .frame_done (fd1),
    .busy       (busy1)
`ifdef SPI_BITREV_FRAME_CNT_EN
    ,
    .frame_cnt  (fc1)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (fd0) done0++;
    if (fd1) done1++;
  end

  // Reference: rx_word places arrival bit i at i (LSB assembly) or at w-1-i (MSB assembly).
  function automatic logic [63:0] exp_rx(input logic [63:0] bits, input int w, input int msb);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (msb != 0) r[w-1-i] = bits[i];
      else          r[i]     = bits[i];
    end
    return r;
  endfunction

  // Reference: the j-th bit the master samples in a slot is the (w-1-j)-th arrival of the prior word.
  function automatic logic [63:0] exp_slot(input logic [63:0] prev, input int w, input bit have);
    logic [63:0] r;
    r = '0;
    if (have) begin
      for (int j = 0; j < w; j++) r[j] = prev[w-1-j];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_word(input int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_rx(input int d);
    return (d == 0) ? 64'(rxw0) : 64'(rxw1);
  endfunction

  task automatic set_ss(input int d, input logic v);
    if (d == 0) ss0 = v;
    else        ss1 = v;
  endtask

  // Mode-0 master: drive mosi while sck low, sample miso just before the rising edge.
  task automatic send_bits(input int d, input logic [63:0] bits, input int n, output logic [63:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      mosi = bits[i];
      #80;
      got[i] = (d == 0) ? miso0 : miso1;
      sck = 1'b1;
      #80;
      sck = 1'b0;
    end
  endtask

  // One chip-select transaction streaming every word in words_q back to back.
  task automatic run_txn(input int d, input int w);
    logic [63:0] got;
    got_q.delete();
    rx_q.delete();
    set_ss(d, 1'b0);
    #160;
    for (int k = 0; k < words_q.size(); k++) begin
      send_bits(d, words_q[k], w, got);
      got_q.push_back(got);
      rx_q.push_back(get_rx(d));
      if (k == 0) busy_mid = (d == 0) ? busy0 : busy1;
    end
    set_ss(d, 1'b1);
    #160;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    resetn = 1'b0;
    #30;
    resetn = 1'b1;
    #100;
  endtask

  task automatic test_reset();
    #23;
    checks++; if (rxw0 !== 8'h00) begin errors++; $display("FAIL reset_rx_word0 got %h expected 00", rxw0); end
    checks++; if (rxw1 !== 13'h0) begin errors++; $display("FAIL reset_rx_word1 got %h expected 0000", rxw1); end
    checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b expected 0", fd0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy0); end
    checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL reset_miso got %b expected 1", miso0); end
    @(negedge clock);
    resetn = 1'b1;
    #100;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", busy0); end
  endtask

  task automatic test_single_word();
    int d0;
    d0 = done0;
    words_q = '{64'h01};
    run_txn(0, W0);
    checks++; if (rx_q[0] !== 64'h01) begin errors++; $display("FAIL single_rx_word got %h expected 01", rx_q[0]); end
    checks++; if (got_q[0] !== 64'h0) begin errors++; $display("FAIL single_first_slot_miso got %h expected 0", got_q[0]); end
    checks++; if (done0 - d0 !== 1) begin errors++; $display("FAIL single_frame_done pulses %0d expected 1", done0 - d0); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL single_busy_active got %b expected 1", busy_mid); end
    checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL single_miso_idle got %b expected 1", miso0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b expected 0", busy0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done0;
    words_q = '{64'h01, 64'h0F};
    run_txn(0, W0);
    checks++; if (rx_q[0] !== 64'h01) begin errors++; $display("FAIL b2b_rx_word1 got %h expected 01", rx_q[0]); end
    checks++; if (got_q[1] !== 64'h80) begin errors++; $display("FAIL b2b_miso_word2 got %h expected 80", got_q[1]); end
    checks++; if (rx_q[1] !== 64'h0F) begin errors++; $display("FAIL b2b_rx_word2 got %h expected 0f", rx_q[1]); end
    checks++; if (done0 - d0 !== 2) begin errors++; $display("FAIL b2b_frame_done pulses %0d expected 2", done0 - d0); end
  endtask

  task automatic test_abort();
    logic [63:0] got;
    logic [63:0] w;
    logic [W0-1:0] rx_before;
    int d0;
    rx_before = rxw0;
    d0 = done0;
    ss0 = 1'b0;
    #160;
    send_bits(0, rand_word(5), 5, got);
    ss0 = 1'b1;
    #200;
    checks++; if (done0 !== d0) begin errors++; $display("FAIL abort_no_frame_done pulses %0d expected 0", done0 - d0); end
    checks++; if (rxw0 !== rx_before) begin errors++; $display("FAIL abort_rx_held got %h expected %h", rxw0, rx_before); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy0); end
    checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL abort_miso got %b expected 1", miso0); end
    w = rand_word(W0);
    words_q = '{w};
    run_txn(0, W0);
    checks++; if (got_q[0] !== 64'h0) begin errors++; $display("FAIL after_abort_first_slot got %h expected 0", got_q[0]); end
    checks++; if (rx_q[0] !== exp_rx(w, W0, 0)) begin errors++; $display("FAIL after_abort_rx got %h expected %h", rx_q[0], exp_rx(w, W0, 0)); end
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] got;
    words_q = '{64'hFF};
    run_txn(0, W0);
    ss0 = 1'b0;
    #160;
    send_bits(0, 64'h7, 3, got);
    #40;
    resetn = 1'b0;
    #1;
    checks++; if (rxw0 !== 8'h00) begin errors++; $display("FAIL midreset_rx_word got %h expected 00", rxw0); end
    checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL midreset_frame_done got %b expected 0", fd0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b expected 0", busy0); end
    ss0 = 1'b1;
    #1;
    checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL midreset_miso got %b expected 1", miso0); end
    #28;
    resetn = 1'b1;
    #100;
    words_q = '{64'hA5};
    run_txn(0, W0);
    checks++; if (rx_q[0] !== 64'hA5) begin errors++; $display("FAIL post_reset_rx got %h expected a5", rx_q[0]); end
    checks++; if (got_q[0] !== 64'h0) begin errors++; $display("FAIL post_reset_first_slot got %h expected 0", got_q[0]); end
  endtask

  task automatic test_random_stream();
    int n;
    int d0;
    for (int t = 0; t < 4; t++) begin
      n = int'($urandom_range(2, 5));
      words_q.delete();
      for (int k = 0; k < n; k++) words_q.push_back(rand_word(W0));
      d0 = done0;
      run_txn(0, W0);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (got_q[k] !== exp_slot((k == 0) ? 64'h0 : words_q[k-1], W0, k != 0)) begin
          errors++;
          $display("FAIL stream%0d_miso_slot%0d got %h expected %h", t, k, got_q[k],
                   exp_slot((k == 0) ? 64'h0 : words_q[k-1], W0, k != 0));
        end
        checks++;
        if (rx_q[k] !== exp_rx(words_q[k], W0, 0)) begin
          errors++;
          $display("FAIL stream%0d_rx_word%0d got %h expected %h", t, k, rx_q[k], exp_rx(words_q[k], W0, 0));
        end
      end
      checks++; if (done0 - d0 !== n) begin errors++; $display("FAIL stream%0d_frame_done pulses %0d expected %0d", t, done0 - d0, n); end
    end
  endtask

  task automatic test_w13_msb_first();
    logic [63:0] w;
    int d0;
    int d1;
    w = rand_word(W1);
    words_q = '{64'h1, w, rand_word(W1)};
    d0 = done0;
    d1 = done1;
    run_txn(1, W1);
    checks++; if (rx_q[0] !== 64'h1000) begin errors++; $display("FAIL w13_rx_word got %h expected 1000", rx_q[0]); end
    checks++; if (got_q[1] !== 64'h1000) begin errors++; $display("FAIL w13_miso_slot2 got %h expected 1000", got_q[1]); end
    checks++; if (rx_q[1] !== exp_rx(w, W1, 1)) begin errors++; $display("FAIL w13_rx_rand got %h expected %h", rx_q[1], exp_rx(w, W1, 1)); end
    checks++; if (got_q[2] !== exp_slot(w, W1, 1'b1)) begin errors++; $display("FAIL w13_miso_slot3 got %h expected %h", got_q[2], exp_slot(w, W1, 1'b1)); end
    checks++; if (done1 - d1 !== 3) begin errors++; $display("FAIL w13_frame_done pulses %0d expected 3", done1 - d1); end
    checks++; if (done0 !== d0) begin errors++; $display("FAIL w13_other_dut_quiet pulses %0d expected 0", done0 - d0); end
  endtask

`ifdef SPI_BITREV_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [63:0] got;
    pulse_reset();
    checks++; if (fc0 !== 16'd0) begin errors++; $display("FAIL frame_cnt_reset got %0d expected 0", fc0); end
    words_q = '{rand_word(W0), rand_word(W0), rand_word(W0)};
    run_txn(0, W0);
    ss0 = 1'b0;
    #160;
    send_bits(0, rand_word(4), 4, got);
    ss0 = 1'b1;
    #200;
    checks++; if (fc0 !== 16'd3) begin errors++; $display("FAIL frame_cnt_total got %0d expected 3", fc0); end
  endtask
`endif

  initial begin
    clock  = 1'b0;
    resetn = 1'b0;
    sck    = 1'b0;
    ss0    = 1'b1;
    ss1    = 1'b1;
    mosi   = 1'b0;
    checks = 0;
    errors = 0;
    done0  = 0;
    done1  = 0;
    busy_mid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_reset_mid_word();
    test_random_stream();
    test_w13_msb_first();
`ifdef SPI_BITREV_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
